case_9_prod_accum: RTL and testbench

- Downstream consumer of the case_9 2s x 2s signed multiplier.
- Takes the 4-bit signed product stream from a FIFO and accumulates LEN consecutive products into one signed sum.
- Writes each sum to an output FIFO.
- Block-level control uses the ap_ctrl_hs protocol (ap_start/ap_done/ap_idle/ap_ready), so the block drops into the generated top-level unchanged.

---
 rtl/case_9_prod_accum_pkg.sv | 36 +++
 rtl/case_9_prod_accum_if.sv | 41 ++++
 rtl/case_9_prod_accum_sat_add.sv | 38 +++
 rtl/case_9_prod_accum.sv | 101 ++++++++++
 tb/tb_case_9_prod_accum.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/case_9_prod_accum_pkg.sv
// rtl/case_9_prod_accum_pkg.sv - shared types, widths and arithmetic helpers for case_9_prod_accum
// Package case_9_accum_pkg:
//   state_t          : IDLE / ACC / OUT controller states (2 bits)
//   CNT_WIDTH        : product counter width, sized for the largest legal LEN
//   sext()           : sign-extend a DIN-wide value held in the low bits of an ACC_MAX word
//   sat_max/sat_min  : two's-complement clamp bounds for a given accumulator width
package case_9_accum_pkg;

  // Widest accumulator the helper functions support.
  localparam int ACC_MAX   = 32;
  // LEN is legal up to 255, so the counter is sized for that worst case.
  localparam int LEN_MAX   = 255;
  localparam int CNT_WIDTH = $clog2(LEN_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Bits above din_width are ignored and replaced by copies of the sign bit.
  function automatic logic [ACC_MAX-1:0] sext(input logic [ACC_MAX-1:0] din, input int din_width);
    logic [ACC_MAX-1:0] hi_mask;
    hi_mask = {ACC_MAX{1'b1}} << din_width;
    return din[din_width-1] ? (din | hi_mask) : (din & ~hi_mask);
  endfunction

  function automatic logic [ACC_MAX-1:0] sat_max(input int width);
    return (ACC_MAX'(1) << (width - 1)) - ACC_MAX'(1);
  endfunction

  function automatic logic [ACC_MAX-1:0] sat_min(input int width);
    return ~sat_max(width);
  endfunction

endpackage

// File: rtl/case_9_prod_accum_if.sv
// rtl/case_9_prod_accum_if.sv - block-control and FIFO handshake bundle for case_9_prod_accum
// Signals:
//   ap_start/ap_done/ap_idle/ap_ready : ap_ctrl_hs block control
//   prod_dout/prod_empty_n/prod_read   : upstream product FIFO (read side)
//   sum_din/sum_full_n/sum_write       : downstream sum FIFO (write side)
//   sum_ovf                            : sticky clamp flag, only with CASE_9_ACC_SAT_EN
// Modports: master drives requests/FIFO status, slave is the accumulator.
interface case_9_prod_accum_if #(
  parameter int DIN_WIDTH = 4,
  parameter int ACC_WIDTH = 8
);
  logic                 ap_start;
  logic                 ap_done;
  logic                 ap_idle;
  logic                 ap_ready;
  logic [DIN_WIDTH-1:0] prod_dout;
  logic                 prod_empty_n;
  logic                 prod_read;
  logic [ACC_WIDTH-1:0] sum_din;
  logic                 sum_full_n;
  logic                 sum_write;
`ifdef CASE_9_ACC_SAT_EN
  logic                 sum_ovf;
`endif

  modport master (
    output ap_start, prod_dout, prod_empty_n, sum_full_n,
    input  ap_done, ap_idle, ap_ready, prod_read, sum_din, sum_write
`ifdef CASE_9_ACC_SAT_EN
    , input sum_ovf
`endif
  );

  modport slave (
    input  ap_start, prod_dout, prod_empty_n, sum_full_n,
    output ap_done, ap_idle, ap_ready, prod_read, sum_din, sum_write
`ifdef CASE_9_ACC_SAT_EN
    , output sum_ovf
`endif
  );
endinterface

// File: rtl/case_9_prod_accum_sat_add.sv
// rtl/case_9_prod_accum_sat_add.sv - combinational two's-complement adder with optional clamp
// Module case_9_sat_add:
//   a_i, b_i : WIDTH-bit signed operands
//   sum_o    : WIDTH-bit result (wrapped, or clamped with CASE_9_ACC_SAT_EN)
//   ovf_o    : signed overflow of this add, only with CASE_9_ACC_SAT_EN
module case_9_sat_add
  import case_9_accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
`ifdef CASE_9_ACC_SAT_EN
  , output logic           ovf_o
`endif
);

  logic [WIDTH-1:0] raw;
  assign raw = a_i + b_i;

`ifdef CASE_9_ACC_SAT_EN
  logic ovf;
  // Overflow only when both operands share a sign that the result lost.
  assign ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
  assign ovf_o = ovf;

  always_comb begin
    sum_o = raw;
    if (ovf) begin
      sum_o = a_i[WIDTH-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
    end
  end
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/case_9_prod_accum.sv
// rtl/case_9_prod_accum.sv - accumulates LEN signed products per sum under ap_ctrl_hs control
// Ports:
//   ap_clk : clock, all state changes on the rising edge
//   ap_rst : synchronous active-high reset
//   bus    : case_9_prod_accum_if.slave (block control, product FIFO, sum FIFO)
// Optional macro CASE_9_ACC_SAT_EN: saturating adds plus sticky bus.sum_ovf flag.
module case_9_prod_accum
  import case_9_accum_pkg::*;
#(
  parameter int DIN_WIDTH = 4,
  parameter int ACC_WIDTH = 8,
  parameter int LEN       = 8
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  case_9_prod_accum_if.slave bus
);

  state_t                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   rd_fire;

  assign prod_ext = ACC_WIDTH'(sext(ACC_MAX'(bus.prod_dout), DIN_WIDTH));
  assign cnt_d    = cnt_q + CNT_WIDTH'(1);

  // Pops and pushes are gated by state, so they can never coincide.
  assign rd_fire       = (state_q == ST_ACC) && bus.prod_empty_n;
  assign bus.prod_read = rd_fire;
  assign bus.sum_write = (state_q == ST_OUT) && bus.sum_full_n;
  assign bus.ap_done   = bus.sum_write;
  assign bus.ap_ready  = bus.sum_write;
  assign bus.ap_idle   = (state_q == ST_IDLE);
  assign bus.sum_din   = acc_q;

`ifdef CASE_9_ACC_SAT_EN
  logic add_ovf;
  logic ovf_q;
  assign bus.sum_ovf = ovf_q;

  case_9_sat_add #(.WIDTH(ACC_WIDTH)) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );
`else
  case_9_sat_add #(.WIDTH(ACC_WIDTH)) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (add_sum)
  );
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef CASE_9_ACC_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ap_start) begin
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef CASE_9_ACC_SAT_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          // An empty FIFO simply holds acc and cnt until data returns.
          if (rd_fire) begin
            acc_q <= add_sum;
            cnt_q <= cnt_d;
`ifdef CASE_9_ACC_SAT_EN
            ovf_q <= ovf_q | add_ovf;
`endif
            if (cnt_d == CNT_WIDTH'(LEN)) begin
              state_q <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (bus.sum_full_n) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_9_prod_accum.sv
// tb/tb_case_9_prod_accum.sv - self-checking bench for case_9_prod_accum
module tb_case_9_prod_accum;

  localparam int LEN = 8;
`ifdef CASE_9_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  case_9_prod_accum_if #(.DIN_WIDTH(4), .ACC_WIDTH(8)) bus  ();
  case_9_prod_accum_if #(.DIN_WIDTH(4), .ACC_WIDTH(4)) bus4 ();

  case_9_prod_accum #(.DIN_WIDTH(4), .ACC_WIDTH(8), .LEN(LEN)) u_dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  case_9_prod_accum #(.DIN_WIDTH(4), .ACC_WIDTH(4), .LEN(LEN)) u_dut4 (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus4)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Written only by the FIFO/monitor process.
  int         cyc = 0, pops = 0, stall_cnt = 0;
  int         bad_pop = 0, overlap = 0, rdy_err = 0, done_cnt = 0;
  logic [7:0] wr_val[$];
  int         wr_cyc[$];
  int         wr_ovf[$];
  int         st_cyc[$];

  // Written only by the test tasks.
  int src[$];
  int stall_at  = -1;
  int stall_len = 0;

  // Upstream FIFO model and output monitor: inputs change on the falling edge,
  // outputs are sampled 1 ns later and act on the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (pops == stall_at && stall_cnt < stall_len) begin
      bus.prod_empty_n = 1'b0;
      stall_cnt++;
    end else begin
      if (pops != stall_at) stall_cnt = 0;
      bus.prod_empty_n = (pops < src.size());
    end
    bus.prod_dout = (pops < src.size()) ? 4'(src[pops]) : 4'h0;
    #1;
    if (!rst) begin
      if (bus.prod_read && !bus.prod_empty_n) bad_pop++;
      if (bus.prod_read && bus.sum_write) overlap++;
      if (bus.ap_done !== bus.ap_ready || bus.ap_done !== bus.sum_write) rdy_err++;
      if (bus.ap_done) done_cnt++;
      if (bus.ap_start && bus.ap_idle) st_cyc.push_back(cyc);
      if (bus.sum_write) begin
        wr_val.push_back(bus.sum_din);
        wr_cyc.push_back(cyc);
`ifdef CASE_9_ACC_SAT_EN
        wr_ovf.push_back(int'(bus.sum_ovf));
`else
        wr_ovf.push_back(0);
`endif
      end
    end
    if (bus.prod_read) pops++;
  end

  // Reference: running sum of the products, either clamped after every add or
  // reduced modulo 2^w at the end.
  function automatic int model_sum(input int p[$], input int w, input bit sat, output bit ovf);
    int lo, hi, span, s;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    span = 1 << w;
    s = 0;
    ovf = 1'b0;
    foreach (p[i]) begin
      s = s + p[i];
      if (sat && s > hi) begin s = hi; ovf = 1'b1; end
      else if (sat && s < lo) begin s = lo; ovf = 1'b1; end
    end
    if (!sat) s = ((s - lo) % span + span) % span + lo;
    return s;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic launch(output bit ok);
    int s0, b;
    s0 = st_cyc.size();
    b = 0;
    bus.ap_start = 1'b1;
    while (st_cyc.size() == s0 && b < 50) begin tick(); b++; end
    bus.ap_start = 1'b0;
    ok = (st_cyc.size() != s0);
  endtask

  task automatic wait_write(input int n_target, input int budget, output bit ok);
    int b;
    b = 0;
    while (wr_val.size() < n_target && b < budget) begin tick(); b++; end
    ok = (wr_val.size() >= n_target);
  endtask

  task automatic wait_pops(input int target, output bit ok);
    int b;
    b = 0;
    while (pops < target && b < 60) begin tick(); b++; end
    ok = (pops >= target);
  endtask

  task automatic test_reset();
    tick(3);
    n_assert++;
    if (bus.ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", bus.ap_idle); end
    n_assert++;
    if ({bus.ap_done, bus.ap_ready, bus.prod_read, bus.sum_write} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {bus.ap_done, bus.ap_ready, bus.prod_read, bus.sum_write});
    end
    n_assert++;
    if (bus.sum_din !== 8'h00) begin n_fail++; $display("FAIL reset_sum_din: got %h want 00", bus.sum_din); end
    n_assert++;
    if (bus4.sum_din !== 4'h0 || bus4.ap_idle !== 1'b1) begin
      n_fail++; $display("FAIL reset_dut4: got sum %h idle %b want 0 1", bus4.sum_din, bus4.ap_idle);
    end
    rst = 1'b0;
    tick();
  endtask

  // Runs one sum with optional upstream stall and checks value, latency and pop count.
  task automatic run_sum(input string name, input int p[$], input int st_off, input int st_len);
    int n0, s0, p0, e;
    bit ok, ok2, ovf;
    n0 = wr_val.size();
    s0 = st_cyc.size();
    p0 = pops;
    foreach (p[i]) src.push_back(p[i]);
    e = model_sum(p, 8, SAT, ovf);
    stall_at  = (st_len > 0) ? p0 + st_off : -1;
    stall_len = st_len;
    launch(ok);
    wait_write(n0 + 1, 80, ok2);
    n_assert++;
    if (!(ok && ok2)) begin
      n_fail++; $display("FAIL %s_timeout: got start %b write %b want 1 1", name, ok, ok2);
    end else begin
      n_assert++;
      if (wr_val[n0] !== 8'(e)) begin n_fail++; $display("FAIL %s_sum: got %h want %h", name, wr_val[n0], 8'(e)); end
      n_assert++;
      if (wr_cyc[n0] - st_cyc[s0] !== LEN + 1 + st_len) begin
        n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, wr_cyc[n0] - st_cyc[s0], LEN + 1 + st_len);
      end
      n_assert++;
      if (pops - p0 !== LEN) begin n_fail++; $display("FAIL %s_pops: got %0d want %0d", name, pops - p0, LEN); end
      n_assert++;
      if (bus.ap_idle !== 1'b1) begin n_fail++; $display("FAIL %s_idle_after: got %b want 1", name, bus.ap_idle); end
`ifdef CASE_9_ACC_SAT_EN
      n_assert++;
      if (wr_ovf[n0] !== int'(ovf)) begin n_fail++; $display("FAIL %s_ovf: got %0d want %0d", name, wr_ovf[n0], ovf); end
`endif
    end
    stall_at = -1;
    stall_len = 0;
    tick();
  endtask

  task automatic test_basic();
    int p[$];
    repeat (LEN) p.push_back(4);
    run_sum("basic", p, 0, 0);
  endtask

  task automatic test_stall();
    int p[$];
    repeat (LEN / 2) begin p.push_back(-2); p.push_back(1); end
    run_sum("stall", p, 3, 3);
    n_assert++;
    if (bad_pop !== 0) begin n_fail++; $display("FAIL stall_empty_pop: got %0d want 0", bad_pop); end
  endtask

  task automatic test_random();
    int p[$];
    for (int k = 0; k < 4; k++) begin
      p.delete();
      repeat (LEN) p.push_back(int'($urandom_range(15)) - 8);
      run_sum("random", p, int'($urandom_range(7, 1)), int'($urandom_range(4)));
    end
  endtask

  task automatic test_full_stall();
    int p[$];
    int n0, p0, d0, e, err;
    bit ok, ok2, ok3, ovf;
    repeat (LEN) p.push_back(int'($urandom_range(15)) - 8);
    foreach (p[i]) src.push_back(p[i]);
    e = model_sum(p, 8, SAT, ovf);
    n0 = wr_val.size();
    p0 = pops;
    d0 = done_cnt;
    err = 0;
    bus.sum_full_n = 1'b0;
    launch(ok);
    wait_pops(p0 + LEN, ok2);
    for (int i = 0; i < 5; i++) begin
      if (bus.sum_write !== 1'b0 || bus.sum_din !== 8'(e)) err++;
      tick();
    end
    n_assert++;
    if (!(ok && ok2) || err !== 0) begin
      n_fail++; $display("FAIL full_hold: got errors %0d start %b pops %b want 0 1 1", err, ok, ok2);
    end
    bus.sum_full_n = 1'b1;
    wait_write(n0 + 1, 10, ok3);
    tick(3);
    n_assert++;
    if (wr_val.size() - n0 !== 1) begin n_fail++; $display("FAIL full_write_count: got %0d want 1", wr_val.size() - n0); end
    n_assert++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", done_cnt - d0); end
    n_assert++;
    if (!ok3 || wr_val[n0] !== 8'(e)) begin
      n_fail++; $display("FAIL full_sum: got %h want %h", ok3 ? wr_val[n0] : 8'hxx, 8'(e));
    end
  endtask

  task automatic test_reset_mid();
    int n0, p0;
    bit ok, ok2, ok3;
    p0 = pops;
    repeat (5) src.push_back(3);
    launch(ok);
    wait_pops(p0 + 5, ok2);
    tick(2);
    n0 = wr_val.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(2);
    n_assert++;
    if (!(ok && ok2) || wr_val.size() !== n0 || bus.ap_idle !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_discard: got writes %0d idle %b want 0 1", wr_val.size() - n0, bus.ap_idle);
    end
    repeat (LEN) src.push_back(1);
    launch(ok);
    wait_write(n0 + 1, 40, ok3);
    n_assert++;
    if (!(ok && ok3) || wr_val[n0] !== 8'd8) begin
      n_fail++; $display("FAIL rst_mid_fresh: got %h want 08", ok3 ? wr_val[n0] : 8'hxx);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n0, s0, b, ov0;
    bit ok;
    n0 = wr_val.size();
    s0 = st_cyc.size();
    ov0 = overlap;
    repeat (3 * LEN) src.push_back(-1);
    bus.ap_start = 1'b1;
    b = 0;
    while (st_cyc.size() < s0 + 3 && b < 80) begin tick(); b++; end
    bus.ap_start = 1'b0;
    wait_write(n0 + 3, 40, ok);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d writes want 3", wr_val.size() - n0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_assert++;
        if (wr_val[n0 + k] !== 8'hF8) begin n_fail++; $display("FAIL b2b_sum%0d: got %h want f8", k, wr_val[n0 + k]); end
      end
      for (int k = 1; k < 3; k++) begin
        n_assert++;
        if (wr_cyc[n0 + k] - wr_cyc[n0 + k - 1] !== LEN + 2) begin
          n_fail++; $display("FAIL b2b_gap%0d: got %0d want %0d", k, wr_cyc[n0 + k] - wr_cyc[n0 + k - 1], LEN + 2);
        end
      end
    end
    n_assert++;
    if (overlap !== ov0) begin n_fail++; $display("FAIL b2b_read_write_overlap: got %0d want 0", overlap - ov0); end
    tick(2);
  endtask

  task automatic test_wrap_sat();
    int p[$];
    int e, b;
    bit ovf;
    repeat (LEN) p.push_back(7);
    e = model_sum(p, 4, SAT, ovf);
    bus4.prod_dout = 4'd7;
    bus4.prod_empty_n = 1'b1;
    bus4.ap_start = 1'b1;
    tick();
    bus4.ap_start = 1'b0;
    b = 0;
    while (bus4.sum_write !== 1'b1 && b < 30) begin tick(); b++; end
    n_assert++;
    if (bus4.sum_write !== 1'b1 || bus4.sum_din !== 4'(e)) begin
      n_fail++; $display("FAIL narrow_sum: got write %b sum %h want 1 %h", bus4.sum_write, bus4.sum_din, 4'(e));
    end
`ifdef CASE_9_ACC_SAT_EN
    n_assert++;
    if (bus4.sum_ovf !== ovf) begin n_fail++; $display("FAIL narrow_ovf: got %b want %b", bus4.sum_ovf, ovf); end
`endif
    bus4.prod_empty_n = 1'b0;
    tick(2);
  endtask

  task automatic test_invariants();
    n_assert++;
    if (rdy_err !== 0) begin n_fail++; $display("FAIL done_ready_write_coincide: got %0d mismatches want 0", rdy_err); end
    n_assert++;
    if (overlap !== 0) begin n_fail++; $display("FAIL read_write_overlap: got %0d want 0", overlap); end
    n_assert++;
    if (bad_pop !== 0) begin n_fail++; $display("FAIL pop_while_empty: got %0d want 0", bad_pop); end
  endtask

  initial begin
    bus.ap_start = 1'b0;
    bus.sum_full_n = 1'b1;
    bus4.ap_start = 1'b0;
    bus4.sum_full_n = 1'b1;
    bus4.prod_empty_n = 1'b0;
    bus4.prod_dout = 4'h0;
    test_reset();
    test_basic();
    test_stall();
    test_full_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_wrap_sat();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
